// File: rtl/mat_mul_seq.sv
// Sequencer that feeds a 16-term signed int8 dot-product MAC to compute C = A x B.
// A rows and B columns sit in local buffers; C comes back row-major through a small result FIFO.
module mat_mul_seq #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int MAC_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_sel,
  input  logic [3:0]         ld_idx,
  input  logic [127:0]       ld_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [127:0]       mac_a,
  output logic [127:0]       mac_b,
  input  logic signed [19:0] mac_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [19:0] res_data,
  output logic [3:0]         res_row,
  output logic [3:0]         res_col,
  output logic               res_last
);
  localparam int DATA_W = 8;
  localparam int VEC_W  = 16 * DATA_W;
  localparam int ACC_W  = 20;
  localparam int STAGES = MAC_LAT + 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + STAGES + 1) + 1;
  localparam int ENT_W  = 1 + 4 + 4 + ACC_W;
  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
  localparam logic [3:0] COL_MAX = 4'(COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t               state;
  logic [VEC_W-1:0]     a_buf [ROWS];
  logic [VEC_W-1:0]     b_buf [COLS];
  logic [3:0]           i_q, j_q;
  logic [STAGES-1:0]    vld_p;
  logic [STAGES-1:0]    last_p;
  logic [3:0]           row_p [STAGES];
  logic [3:0]           col_p [STAGES];
  logic [ENT_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count_q;
  logic [OCC_W-1:0]     occ;
  logic                 pop, capture, issue, last_issue;

  // A pop in the same cycle frees a slot, which keeps issue at one per cycle while draining.
  always_comb begin
    occ = OCC_W'(count_q) - OCC_W'(pop);
    for (int k = 0; k < STAGES; k++) occ = occ + OCC_W'(vld_p[k]);
  end

  assign pop        = res_valid && res_ready;
  assign capture    = vld_p[STAGES-1];
  assign last_issue = (i_q == ROW_MAX) && (j_q == COL_MAX);
  assign issue      = (state == RUN) && (occ < OCC_W'(FIFO_DEPTH));
  assign done       = (state == DRAIN) && pop && res_last;
  assign ld_ready   = !busy;
  assign res_valid  = (count_q != '0);
  assign {res_last, res_row, res_col, res_data} = fifo_mem[rd_ptr];

  // Operand buffers: out-of-range indices must not alias onto a valid entry.
  always_ff @(posedge clk) begin
    if (ld_valid && ld_ready) begin
      if (!ld_sel && (ld_idx <= ROW_MAX)) a_buf[ld_idx[ROW_W-1:0]] <= ld_data;
      if (ld_sel && (ld_idx <= COL_MAX))  b_buf[ld_idx[COL_W-1:0]] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      i_q   <= '0;
      j_q   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          i_q   <= '0;
          j_q   <= '0;
        end
        RUN: if (issue) begin
          if (last_issue) begin
            state <= DRAIN;
          end else if (j_q == COL_MAX) begin
            j_q <= '0;
            i_q <= i_q + 4'd1;
          end else begin
            j_q <= j_q + 4'd1;
          end
        end
        DRAIN: if (done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p0: operand registration; tags then ride alongside the MAC pipeline to p[STAGES-1].
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mac_a  <= '0;
      mac_b  <= '0;
      vld_p  <= '0;
      last_p <= '0;
      for (int k = 0; k < STAGES; k++) begin
        row_p[k] <= '0;
        col_p[k] <= '0;
      end
    end else begin
      if (issue) begin
        mac_a <= a_buf[i_q[ROW_W-1:0]];
        mac_b <= b_buf[j_q[COL_W-1:0]];
      end
      vld_p[0]  <= issue;
      last_p[0] <= last_issue;
      row_p[0]  <= i_q;
      col_p[0]  <= j_q;
      for (int k = 1; k < STAGES; k++) begin
        vld_p[k]  <= vld_p[k-1];
        last_p[k] <= last_p[k-1];
        row_p[k]  <= row_p[k-1];
        col_p[k]  <= col_p[k-1];
      end
    end
  end

  // Result capture: mac_out lines up with the oldest tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo_mem[k] <= '0;
    end else begin
      if (capture) begin
        fifo_mem[wr_ptr] <= {last_p[STAGES-1], row_p[STAGES-1], col_p[STAGES-1], mac_out};
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({capture, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: behavioural 2-stage MAC, queue scoreboards, 4x4 table cases and a 3x5 random run.
module tb_mat_mul_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic               ld_valid, ld_ready, ld_sel, start, busy, done;
  logic               res_valid, res_ready, res_last;
  logic [3:0]         ld_idx, res_row, res_col;
  logic [127:0]       ld_data, mac_a, mac_b;
  logic signed [19:0] mac_out, res_data;
  int                 mac_p1;

  logic               ld_valid2, ld_ready2, ld_sel2, start2, busy2, done2;
  logic               res_valid2, res_ready2, res_last2;
  logic [3:0]         ld_idx2, res_row2, res_col2;
  logic [127:0]       ld_data2, mac_a2, mac_b2;
  logic signed [19:0] mac_out2, res_data2;
  int                 mac2_p1;

  mat_mul_seq #(.ROWS(4), .COLS(4), .MAC_LAT(2), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_idx(ld_idx), .ld_data(ld_data), .start(start), .busy(busy), .done(done),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_row(res_row), .res_col(res_col),
    .res_last(res_last));

  mat_mul_seq #(.ROWS(3), .COLS(5), .MAC_LAT(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid2), .ld_ready(ld_ready2), .ld_sel(ld_sel2),
    .ld_idx(ld_idx2), .ld_data(ld_data2), .start(start2), .busy(busy2), .done(done2),
    .mac_a(mac_a2), .mac_b(mac_b2), .mac_out(mac_out2), .res_valid(res_valid2),
    .res_ready(res_ready2), .res_data(res_data2), .res_row(res_row2), .res_col(res_col2),
    .res_last(res_last2));

  function automatic int dot(logic [127:0] a, logic [127:0] b);
    int s = 0;
    for (int k = 0; k < 16; k++) s += int'($signed(a[8*k +: 8])) * int'($signed(b[8*k +: 8]));
    return s;
  endfunction

  function automatic logic [127:0] splat(int v);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = 8'(v);
    return r;
  endfunction

  // External MAC model: products at the first edge, sum visible after the second.
  always @(posedge clk) begin
    mac_p1   <= dot(mac_a, mac_b);
    mac_out  <= 20'(mac_p1);
    mac2_p1  <= dot(mac_a2, mac_b2);
    mac_out2 <= 20'(mac2_p1);
  end

  typedef struct {int row; int col; int data; bit last;} exp_t;
  typedef struct {int a; int b[4]; int c[4];} vec_t;

  exp_t q1[$], q2[$];
  vec_t tbl[5];
  int   n_cmp = 0, n_err = 0;
  int   pops1 = 0, done1_cnt = 0, done2_cnt = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (reset_n) begin
      chk("ld_ready_vs_busy", int'(ld_ready), int'(!busy));
      if (res_valid && res_ready) begin
        if (q1.size() == 0) fail("unexpected_result");
        else begin
          e = q1.pop_front();
          chk("row", int'(res_row), e.row);
          chk("col", int'(res_col), e.col);
          chk("data", int'(res_data), e.data);
          chk("last", int'(res_last), int'(e.last));
          chk("done_at_pop", int'(done), int'(e.last));
        end
        pops1++;
      end else begin
        if (done) fail("done_without_pop");
        if (res_valid && q1.size() != 0) begin
          chk("head_row_stall", int'(res_row), q1[0].row);
          chk("head_col_stall", int'(res_col), q1[0].col);
        end
      end
      if (done) done1_cnt++;
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (reset_n) begin
      if (res_valid2 && res_ready2) begin
        if (q2.size() == 0) fail("unexpected_result2");
        else begin
          e = q2.pop_front();
          chk("row2", int'(res_row2), e.row);
          chk("col2", int'(res_col2), e.col);
          chk("data2", int'(res_data2), e.data);
          chk("last2", int'(res_last2), int'(e.last));
          chk("done2_at_pop", int'(done2), int'(e.last));
        end
      end else if (done2) fail("done2_without_pop");
      if (done2) done2_cnt++;
    end
  end

  task automatic load1(bit sel, int idx, logic [127:0] d);
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_sel = sel; ld_idx = 4'(idx); ld_data = d;
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic load2(bit sel, int idx, logic [127:0] d);
    @(posedge clk); #1;
    ld_valid2 = 1'b1; ld_sel2 = sel; ld_idx2 = 4'(idx); ld_data2 = d;
    @(posedge clk); #1;
    ld_valid2 = 1'b0;
  endtask

  task automatic load_case(int t);
    for (int r = 0; r < 4; r++) load1(1'b0, r, splat(tbl[t].a));
    for (int c = 0; c < 4; c++) load1(1'b1, c, splat(tbl[t].b[c]));
    load1(1'b0, 7, splat(99));
    load1(1'b1, 12, splat(99));
  endtask

  task automatic push_case(int t);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) q1.push_back('{r, c, tbl[t].c[c], (r == 3 && c == 3)});
  endtask

  task automatic pulse_start1();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done1(string name, int d0);
    int n = 0;
    while ((busy || q1.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) fail(name);
    chk({name, "_done_once"}, done1_cnt - d0, 1);
  endtask

  initial begin
    int d0, p0, n;
    logic [127:0] ra [3];
    logic [127:0] rb [5];

    tbl[0].a = 1;    tbl[0].b = '{1, 2, 3, 4};             tbl[0].c = '{16, 32, 48, 64};
    tbl[1].a = -128; tbl[1].b = '{-128, -128, -128, -128}; tbl[1].c = '{262144, 262144, 262144, 262144};
    tbl[2].a = -128; tbl[2].b = '{127, 127, 127, 127};     tbl[2].c = '{-260096, -260096, -260096, -260096};
    tbl[3].a = 3;    tbl[3].b = '{-1, 0, 5, -7};           tbl[3].c = '{-48, 0, 240, -336};
    tbl[4].a = 127;  tbl[4].b = '{127, -128, 1, -1};       tbl[4].c = '{258064, -260096, 2032, -2032};

    reset_n = 1'b0;
    ld_valid = 1'b0; ld_sel = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0; res_ready = 1'b1;
    ld_valid2 = 1'b0; ld_sel2 = 1'b0; ld_idx2 = '0; ld_data2 = '0; start2 = 1'b0; res_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_last", int'(res_last), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_res_rowcol", int'({res_row, res_col}), 0);
    chk("rst_mac_zero", int'(mac_a == '0 && mac_b == '0), 1);
    chk("rst_ld_ready", int'(ld_ready), 1);
    reset_n = 1'b1;

    // Table-driven cases, first one also checks start-to-result latency.
    for (int t = 0; t < 5; t++) begin
      load_case(t);
      push_case(t);
      d0 = done1_cnt;
      pulse_start1();
      chk("busy_after_start", int'(busy), 1);
      if (t == 0) begin
        for (int k = 1; k <= 4; k++) begin
          @(posedge clk); #1;
          chk($sformatf("latency_edge%0d", k), int'(res_valid), int'(k == 4));
        end
      end
      wait_done1($sformatf("case%0d", t), d0);
      chk("idle_after_done", int'(busy), 0);
    end

    // Back-pressure: FIFO fills to its depth, issue stalls, then everything drains in order.
    load_case(0);
    res_ready = 1'b0;
    push_case(0);
    d0 = done1_cnt;
    pulse_start1();
    repeat (20) @(posedge clk);
    #1;
    chk("hold_fifo_count", int'(u_dut.count_q), 4);
    chk("hold_inflight", int'(u_dut.vld_p), 0);
    chk("hold_res_valid", int'(res_valid), 1);
    chk("hold_head_data", int'(res_data), 16);
    chk("hold_busy", int'(busy), 1);
    res_ready = 1'b1;
    wait_done1("hold", d0);

    // Reset mid-run after the 5th pop; buffers survive and a new run is correct.
    push_case(0);
    p0 = pops1;
    pulse_start1();
    n = 0;
    while (pops1 < p0 + 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) fail("wait_5th_pop");
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_mac_a", int'(mac_a == '0), 1);
    q1.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    push_case(0);
    d0 = done1_cnt;
    pulse_start1();
    wait_done1("after_reset", d0);

    // start and loads while busy must be ignored.
    load_case(1);
    push_case(1);
    d0 = done1_cnt;
    pulse_start1();
    @(posedge clk); #1;
    start = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_idx = 4'd0; ld_data = splat(1);
    chk("busy_ld_ready", int'(ld_ready), 0);
    @(posedge clk); #1;
    start = 1'b0; ld_sel = 1'b1; ld_idx = 4'd0; ld_data = splat(2);
    @(posedge clk); #1;
    start = 1'b1; ld_sel = 1'b1; ld_idx = 4'd1; ld_data = splat(3);
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b0;
    wait_done1("ignore", d0);

    // 3x5 instance: random operands and random back-pressure.
    for (int r = 0; r < 3; r++) begin
      ra[r] = {$urandom, $urandom, $urandom, $urandom};
      load2(1'b0, r, ra[r]);
    end
    for (int c = 0; c < 5; c++) begin
      rb[c] = {$urandom, $urandom, $urandom, $urandom};
      load2(1'b1, c, rb[c]);
    end
    load2(1'b0, 4, splat(55));
    load2(1'b1, 8, splat(-55));
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) q2.push_back('{r, c, dot(ra[r], rb[c]), (r == 2 && c == 4)});
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0;
    while ((busy2 || q2.size() != 0) && n < 600) begin
      @(posedge clk); #1;
      res_ready2 = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 600) fail("random_run");
    res_ready2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done2_count", done2_cnt, 1);
    chk("random_idle", int'(busy2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mat_mul_seq.md
Name: mat_mul_seq

Overview:
- Sequencer that drives the 16-term signed int8 dot-product MAC (`mac`) to compute C = A x B.
- A is ROWS x 16 and B is 16 x COLS.
- Holds A rows and B columns in local buffers, issues one (row, column) operand pair per cycle to the pipelined MAC, and captures each 20-bit result into a small result FIFO.
- Returns results in row-major order over a valid/ready stream.
- Sits between the host load/readback logic and the `mac` datapath instance.

Parameters:
- ROWS, 4, number of rows of A and of C (1..16).
- COLS, 4, number of columns of B and of C (1..16).
- MAC_LAT, 2, MAC latency in clock edges from operand registration to a valid mac_out.
- FIFO_DEPTH, 4, result FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load strobe; accepted only when ld_ready=1.
- ld_ready  out  1  equals !busy.
- ld_sel  in  1  0 selects an A row, 1 selects a B column.
- ld_idx  in  4  row index (A) or column index (B); out-of-range indices are ignored.
- ld_data  in  128  16 signed int8 elements; element k is at [8k+7:8k].
- start  in  1  single-cycle pulse that begins a run; honoured only in IDLE.
- busy  out  1  high from the start edge until done.
- done  out  1  one-cycle pulse, coincident with the handshake of the last result.
- mac_a  out  128  operand vector A[i][*], registered.
- mac_b  out  128  operand vector B[*][j], registered; the MAC multiplies mac_a element k by mac_b element k.
- mac_out  in  20  signed MAC sum.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  consumer accepts a result.
- res_data  out  20  signed C[i][j].
- res_row  out  4  i of the result at the FIFO head.
- res_col  out  4  j of the result at the FIFO head.
- res_last  out  1  high when the head result is (ROWS-1, COLS-1).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; busy, done, res_valid, res_last = 0.
  - mac_a, mac_b, res_data, res_row, res_col = 0.
  - FIFO and in-flight tags are cleared.
  - A/B buffer contents are not reset.
- Loading: on an edge with ld_valid && ld_ready, ld_data is written to A[ld_idx] or B[ld_idx]. Writes while busy are dropped.
- States:
  - IDLE: start moves to RUN and sets busy; (i, j) = (0, 0).
  - RUN: issue when occ < FIFO_DEPTH, where occ = FIFO count + in-flight count. Issue means: at the edge, mac_a <= A[i], mac_b <= B[j], and a tag {valid, i, j, last} enters the in-flight shift register. Then advance j; on j wrap, advance i. After issuing (ROWS-1, COLS-1), move to DRAIN.
  - DRAIN: no further issues; move to IDLE (busy=0) on the edge where the last result is popped. done=1 for that one cycle.
- When not issuing, mac_a and mac_b hold their values. Only tags mark valid results.
- Capture: operands registered at edge E are written into the FIFO from mac_out at edge E+MAC_LAT+1, using the tag (depth MAC_LAT+1).
- The occupancy rule guarantees the FIFO never overflows, so results are never dropped.
- Throughput: one issue per cycle while res_ready=1.
- Latency: start sampled at edge S gives first issue at S+1 and first res_valid after edge S+MAC_LAT+2.
- Pop: on res_valid && res_ready. A simultaneous capture and pop in one edge is legal; the count is unchanged.
- The head fields (res_data, res_row, res_col, res_last) stay stable while res_valid && !res_ready.
- Arithmetic: max |sum| = 16 x 16384 = 262144, which fits a signed 20-bit value; no saturation is needed.
- start in RUN/DRAIN is ignored. Reset mid-run aborts immediately; in-flight results are discarded.

Test Plan:
- A all 1, B column j all (j+1), ROWS=COLS=4, res_ready=1 → 16 results in row-major order with C[i][j] = 16,32,48,64 per row. First res_valid after edge S+4. res_last and done only on (3,3).
- A all -128, B all -128 → every result is 262144. Then B all 127 → every result is -260096. No overflow.
- Hold res_ready=0 for 20 cycles after start → exactly FIFO_DEPTH results held, occ stays ≤ 4, issue stalls. On release, all 16 results arrive in order with no loss or duplication.
- Assert reset_n=0 after the 5th pop → res_valid=0 and busy=0 immediately. A new start yields all 16 correct results.
- start pulses during RUN and ld_valid writes while busy → both ignored; results match the pre-start buffers and ld_ready=0 throughout.
- Random A/B with random res_ready (50%), ROWS=3, COLS=5 → every (row, col, data) matches the software model, and done fires exactly once.
